imem_loader: RTL and testbench

- Write-side counterpart to the fetch stage's instruction-memory read port.
- Accepts a byte stream (length header, payload words, checksum trailer) and assembles little-endian 32-bit words.
- Writes each word into imemory through its read_write/data_in/address port, starting at the reset PC.
- Holds the core in reset (cpu_hold) until the image is loaded and the checksum is verified.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_to_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Types and constants shared by the instruction-memory loader and the fetch stage.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Fetch starts executing here after reset, so the image is loaded from this address.
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; the word is presented
// combinationally together with the fourth accepted byte.
module byte_to_word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [23:0] buf_q;

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            idx_q <= '0;
        end else if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Shifting right leaves byte k at bits [8k+7:8k] once the fourth byte arrives.
    always_ff @(posedge clock) begin
        if (byte_valid_i) begin
            buf_q <= {byte_i, buf_q[23:8]};
        end
    end

    assign word_o       = {byte_i, buf_q};
    assign word_valid_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed program image into instruction memory
// and holds the core in reset until the image has been verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = RESET_PC,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] words_written
);

    state_t      state_q, state_d;
    logic [31:0] n_q, widx_q, csum_q, addr_q, data_q;
    logic        ready_q, we_q, hold_q, busy_q, done_q, err_q;

    logic        accept;
    logic        clear;
    logic [31:0] word;
    logic        word_valid;

    assign accept = in_valid && ready_q;
    assign clear  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    byte_to_word_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (clear),
        .byte_valid_i(accept),
        .byte_i      (in_data),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN;
            S_LEN: begin
                if (word_valid) begin
                    if (word == 32'd0)           state_d = S_CSUM;
                    else if (word > MAX_WORDS)   state_d = S_ERROR;
                    else                         state_d = S_DATA;
                end
            end
            S_DATA:  if (word_valid) state_d = S_WRITE;
            S_WRITE: state_d = (widx_q + 32'd1 == n_q) ? S_CSUM : S_DATA;
            S_CSUM:  if (word_valid) state_d = (word == csum_q) ? S_DONE : S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            widx_q  <= '0;
            csum_q  <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= state_d inside {S_LEN, S_DATA, S_CSUM};
            we_q    <= (state_d == S_WRITE);
            hold_q  <= (state_d != S_DONE);
            busy_q  <= state_d inside {S_LEN, S_DATA, S_WRITE, S_CSUM};
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERROR);

            if (clear) begin
                n_q    <= '0;
                widx_q <= '0;
                csum_q <= '0;
            end
            if (state_q == S_LEN && word_valid) begin
                n_q <= word;
            end
            if (state_q == S_DATA && word_valid) begin
                addr_q <= BASE_ADDR + {widx_q[29:0], 2'b00};
                data_q <= word;
            end
            if (state_q == S_WRITE) begin
                widx_q <= widx_q + 32'd1;
                csum_q <= csum_q + data_q;
            end
        end
    end

    assign in_ready      = ready_q;
    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_data     = data_q;
    assign cpu_hold      = hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;
    assign words_written = widx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader: streams images through the byte port and
// compares observed memory writes and status against a stream-parsing model.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int unsigned MAXW = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, cpu_hold, busy, done, error;
    logic [31:0] imem_addr, imem_data, words_written;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream_q[$];
    logic [31:0] wr_addr_q[$], wr_data_q[$], exp_addr_q[$], exp_data_q[$];
    time         wr_t_q[$], acc_t_q[$];
    logic        exp_done, exp_err;
    logic [31:0] exp_ww;

    imem_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_written(words_written)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_data);
            wr_t_q.push_back($time);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_ready: in_ready=%b during write, required 0", in_ready);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stream_q.push_back(w[8*k +: 8]);
    endtask

    task automatic build_nominal(input logic [31:0] trailer);
        stream_q.delete();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'h0010_0093);
        push_word(trailer);
    endtask

    task automatic build_random(input int n, input bit corrupt);
        logic [31:0] w, sum;
        stream_q.delete();
        push_word(n);
        sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            push_word(w);
            sum += w;
        end
        push_word(corrupt ? (sum ^ (32'd1 << $urandom_range(31))) : sum);
    endtask

    // Reference: parse the stream as header / payload words / trailer.
    task automatic model_stream();
        logic [31:0] n, w, sum, trailer;
        exp_addr_q.delete();
        exp_data_q.delete();
        n = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
        if (n > MAXW) begin
            exp_done = 1'b0; exp_err = 1'b1; exp_ww = 32'd0;
            return;
        end
        sum = 32'd0;
        for (int i = 0; i < int'(n); i++) begin
            w = {stream_q[4+4*i+3], stream_q[4+4*i+2], stream_q[4+4*i+1], stream_q[4+4*i]};
            exp_addr_q.push_back(BASE + 32'(4 * i));
            exp_data_q.push_back(w);
            sum += w;
        end
        trailer = {stream_q[4+4*n+3], stream_q[4+4*n+2], stream_q[4+4*n+1], stream_q[4+4*n]};
        exp_done = (trailer == sum);
        exp_err  = !exp_done;
        exp_ww   = n;
    endtask

    task automatic send_range(input int from, input int to, input int maxgap);
        for (int i = from; i < to; i++) begin
            int wait_cyc;
            if (maxgap > 0) repeat ($urandom_range(maxgap)) @(negedge clock);
            in_valid = 1'b1;
            in_data  = stream_q[i];
            wait_cyc = 0;
            while (in_ready !== 1'b1 && wait_cyc < 50) begin
                @(negedge clock);
                wait_cyc++;
            end
            if (in_ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL accept_timeout: byte %0d in_ready=%b, required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            acc_t_q.push_back($time);
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        wr_addr_q.delete(); wr_data_q.delete(); wr_t_q.delete(); acc_t_q.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({imem_we, imem_addr, imem_data, in_ready, cpu_hold, busy, done, error, words_written}
            !== {1'b0, BASE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h rdy=%b hold=%b busy=%b done=%b err=%b ww=%0d, required 0 01000000 00000000 0 1 0 0 0 0",
                     imem_we, imem_addr, imem_data, in_ready, cpu_hold, busy, done, error, words_written);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({in_ready, cpu_hold, busy} !== 3'b010) begin
            errors++;
            $display("FAIL idle_hold: rdy/hold/busy=%b, required 010", {in_ready, cpu_hold, busy});
        end
    endtask

    task automatic test_nominal();
        build_nominal(32'h0010_00A6);
        do_start();
        send_range(0, 16, 0);
        checks++;
        if ({cpu_hold, done, error} !== 3'b010) begin
            errors++;
            $display("FAIL nominal_release: hold/done/err=%b right after trailer, required 010", {cpu_hold, done, error});
        end
        checks++;
        if (wr_data_q.size() != 2) begin
            errors++;
            $display("FAIL nominal_count: %0d writes, required 2", wr_data_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== BASE || wr_data_q[0] !== 32'h0000_0013) begin
                errors++;
                $display("FAIL nominal_w0: %h@%h, required 00000013@01000000", wr_data_q[0], wr_addr_q[0]);
            end
            checks++;
            if (wr_addr_q[1] !== BASE + 32'd4 || wr_data_q[1] !== 32'h0010_0093) begin
                errors++;
                $display("FAIL nominal_w1: %h@%h, required 00100093@01000004", wr_data_q[1], wr_addr_q[1]);
            end
            checks++;
            if (acc_t_q.size() < 16 || wr_t_q[0] != acc_t_q[7] + 10 || wr_t_q[1] != acc_t_q[11] + 10) begin
                errors++;
                $display("FAIL write_latency: writes at %0t/%0t, required one cycle after byte 7/11", wr_t_q[0], wr_t_q[1]);
            end
        end
        checks++;
        if (words_written !== 32'd2 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL nominal_status: ww=%0d busy=%b rdy=%b, required 2 0 0", words_written, busy, in_ready);
        end
    endtask

    task automatic test_empty();
        stream_q.delete();
        push_word(32'd0);
        push_word(32'd0);
        do_start();
        checks++;
        if (words_written !== 32'd0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: ww=%0d hold=%b busy=%b, required 0 1 1", words_written, cpu_hold, busy);
        end
        send_range(0, 8, 0);
        @(negedge clock);
        checks++;
        if (wr_data_q.size() != 0 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL empty_image: writes=%0d done=%b hold=%b, required 0 1 0", wr_data_q.size(), done, cpu_hold);
        end
    endtask

    task automatic test_oversize();
        stream_q.delete();
        push_word(MAXW + 1);
        do_start();
        send_range(0, 4, 0);
        checks++;
        if ({error, in_ready, cpu_hold, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL oversize_error: err/rdy/hold/busy=%b after header, required 1010", {error, in_ready, cpu_hold, busy});
        end
        in_valid = 1'b1;
        repeat (6) @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (wr_data_q.size() != 0 || in_ready !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL oversize_quiet: writes=%0d rdy=%b err=%b, required 0 0 1", wr_data_q.size(), in_ready, error);
        end
    endtask

    task automatic test_bad_checksum();
        build_nominal(32'h0010_00A7);
        do_start();
        send_range(0, 16, 0);
        checks++;
        if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h0000_0013 || wr_data_q[1] !== 32'h0010_0093) begin
            errors++;
            $display("FAIL badsum_writes: %0d writes, required 2 (00000013, 00100093)", wr_data_q.size());
        end
        checks++;
        if ({error, cpu_hold, done, words_written} !== {1'b1, 1'b1, 1'b0, 32'd2}) begin
            errors++;
            $display("FAIL badsum_status: err=%b hold=%b done=%b ww=%0d, required 1 1 0 2", error, cpu_hold, done, words_written);
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 10; it++) begin
            bit ok;
            if (it == 0) build_nominal(32'h0010_00A6);
            else build_random($urandom_range(1, 6), $urandom_range(3) == 0);
            model_stream();
            do_start();
            send_range(0, stream_q.size(), 3);
            repeat (2) @(negedge clock);
            ok = (wr_data_q.size() == exp_data_q.size());
            for (int i = 0; ok && i < exp_data_q.size(); i++)
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) ok = 0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL gaps_mem it=%0d: %0d writes, required %0d matching model", it, wr_data_q.size(), exp_data_q.size());
            end
            checks++;
            if ({done, error, cpu_hold, words_written} !== {exp_done, exp_err, !exp_done, exp_ww}) begin
                errors++;
                $display("FAIL gaps_status it=%0d: done=%b err=%b hold=%b ww=%0d, required %b %b %b %0d",
                         it, done, error, cpu_hold, words_written, exp_done, exp_err, !exp_done, exp_ww);
            end
        end
    endtask

    task automatic test_start_ignored();
        build_nominal(32'h0010_00A6);
        do_start();
        send_range(0, 6, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_range(6, 16, 1);
        @(negedge clock);
        checks++;
        if (wr_data_q.size() != 2 || done !== 1'b1 || words_written !== 32'd2) begin
            errors++;
            $display("FAIL start_ignored: writes=%0d done=%b ww=%0d, required 2 1 2", wr_data_q.size(), done, words_written);
        end
    endtask

    task automatic test_reset_restart();
        build_nominal(32'h0010_00A6);
        do_start();
        send_range(0, 6, 0);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({imem_we, imem_addr, imem_data, in_ready, cpu_hold, busy, done, error, words_written}
            !== {1'b0, BASE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL midload_reset: we=%b addr=%h data=%h rdy=%b hold=%b busy=%b done=%b err=%b ww=%0d, required reset values",
                     imem_we, imem_addr, imem_data, in_ready, cpu_hold, busy, done, error, words_written);
        end
        reset = 1'b0;
        @(negedge clock);
        do_start();
        send_range(0, 16, 2);
        @(negedge clock);
        checks++;
        if (wr_data_q.size() != 2 || wr_addr_q[0] !== BASE || wr_data_q[0] !== 32'h0000_0013 ||
            wr_addr_q[1] !== BASE + 32'd4 || wr_data_q[1] !== 32'h0010_0093) begin
            errors++;
            $display("FAIL reload_mem: %0d writes, required 00000013@01000000 00100093@01000004", wr_data_q.size());
        end
        checks++;
        if (words_written !== 32'd2 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL reload_status: ww=%0d done=%b hold=%b, required 2 1 0", words_written, done, cpu_hold);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_nominal();
        test_empty();
        test_oversize();
        test_bad_checksum();
        test_back_to_back();
        test_start_ignored();
        test_reset_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
